// File: rtl/sd_cmd_issuer_if.sv
// Purpose: request handshake plus register bus between the command issuer and
//          its neighbours (command source upstream, SD host register port downstream).
// Ports:   req_* request handshake, reg_* register bus, done/timeout/resp completion.
interface sd_cmd_issuer_if;
  logic        req_valid;
  logic        req_ready;
  logic [5:0]  req_cmd_index;
  logic [7:0]  req_cmd_flags;
  logic [31:0] req_arg;

  logic [11:0] reg_address;
  logic [31:0] reg_wr_data;
  logic        reg_wr_en;
  logic [31:0] reg_rd_data;

  logic        done;
  logic        timeout;
  logic [31:0] resp;

  // master: the issuer itself
  modport master (
    input  req_valid, req_cmd_index, req_cmd_flags, req_arg, reg_rd_data,
    output req_ready, reg_address, reg_wr_data, reg_wr_en, done, timeout, resp
  );

  // slave: request source and SD host register port seen from outside
  modport slave (
    output req_valid, req_cmd_index, req_cmd_flags, req_arg, reg_rd_data,
    input  req_ready, reg_address, reg_wr_data, reg_wr_en, done, timeout, resp
  );
endinterface

// File: rtl/sd_cmd_issuer.sv
// Purpose: runs the register sequence for one SD command (busy check, ARG0/ARG1/CMD
//          writes, settle, busy poll with timeout, 32-bit response read-back).
// Latency: 16 cycles accept-to-done with no busy; each extra busy sample adds 2 cycles.
// Backpressure: req_ready is high only in IDLE; requests are held off, never dropped.
// Ports: CLK/RESET (sync, active-high); bus = sd_cmd_issuer_if.master.
module sd_cmd_issuer #(
  parameter logic [11:0] ADDR_ARG0      = 12'h008,
  parameter logic [11:0] ADDR_ARG1      = 12'h00A,
  parameter logic [11:0] ADDR_CMD       = 12'h00E,
  parameter logic [11:0] ADDR_PSR       = 12'h024,
  parameter logic [11:0] ADDR_RESP0     = 12'h010,
  parameter logic [11:0] ADDR_RESP1     = 12'h012,
  parameter int unsigned SETTLE_CYCLES  = 4,     // must be >= 1
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input  logic             CLK,
  input  logic             RESET,
  sd_cmd_issuer_if.master  bus
);

  typedef enum logic [3:0] {
    S_IDLE, S_PRECHECK, S_WR_ARG0, S_WR_ARG1, S_WR_CMD,
    S_SETTLE, S_POLL, S_RD_RESP0, S_RD_RESP1, S_DONE
  } state_t;

  localparam logic [15:0] SETTLE_LAST = 16'(SETTLE_CYCLES - 1);
  localparam logic [15:0] TMO_LIMIT   = 16'(TIMEOUT_CYCLES);

  state_t      state_q, state_d;
  logic        phase_q, phase_d;     // 0 = read phase A, 1 = read phase B
  logic [15:0] cnt_q, cnt_d;         // cycles spent in current state (settle / poll)
  logic [15:0] cnt_inc;
  logic [5:0]  idx_q, idx_d;
  logic [7:0]  flags_q, flags_d;
  logic [31:0] arg_q, arg_d;
  logic [31:0] resp_q, resp_d;
  logic        timeout_q, timeout_d;
  logic        busy_expired;

  logic [11:0] addr_c;
  logic [31:0] wdata_c;
  logic        wr_en_c;
  logic        done_c;
  logic        ready_c;

  // Upper half of the read bus carries nothing for this block.
  logic unused_rd_hi;
  assign unused_rd_hi = ^bus.reg_rd_data[31:16];

  always_comb begin
    state_d   = state_q;
    phase_d   = 1'b0;
    idx_d     = idx_q;
    flags_d   = flags_q;
    arg_d     = arg_q;
    resp_d    = resp_q;
    timeout_d = timeout_q;
    addr_c    = 12'h000;
    wdata_c   = 32'h0;
    wr_en_c   = 1'b0;
    done_c    = 1'b0;
    ready_c   = 1'b0;

    // Saturating count; the value tested at a busy sample includes the current
    // cycle, so a poll phase spends at most TIMEOUT_CYCLES cycles.
    cnt_inc      = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;
    busy_expired = (cnt_inc >= TMO_LIMIT);

    case (state_q)
      S_IDLE: begin
        ready_c = 1'b1;
        if (bus.req_valid) begin
          idx_d     = bus.req_cmd_index;
          flags_d   = bus.req_cmd_flags;
          arg_d     = bus.req_arg;
          resp_d    = 32'h0;
          timeout_d = 1'b0;
          state_d   = S_PRECHECK;
        end
      end
      S_PRECHECK, S_POLL: begin
        addr_c = ADDR_PSR;
        if (!phase_q) begin
          phase_d = 1'b1;
        end else if (!bus.reg_rd_data[0]) begin
          state_d = (state_q == S_PRECHECK) ? S_WR_ARG0 : S_RD_RESP0;
        end else if (busy_expired) begin
          timeout_d = 1'b1;
          state_d   = S_DONE;
        end
        // still busy and within budget: phase_d=0 restarts the read
      end
      S_WR_ARG0: begin
        addr_c  = ADDR_ARG0;
        wdata_c = {16'h0, arg_q[15:0]};
        wr_en_c = 1'b1;
        state_d = S_WR_ARG1;
      end
      S_WR_ARG1: begin
        addr_c  = ADDR_ARG1;
        wdata_c = {16'h0, arg_q[31:16]};
        wr_en_c = 1'b1;
        state_d = S_WR_CMD;
      end
      S_WR_CMD: begin
        addr_c  = ADDR_CMD;
        wdata_c = {16'h0, 2'b00, idx_q, flags_q};
        wr_en_c = 1'b1;
        state_d = S_SETTLE;
      end
      S_SETTLE: begin
        if (cnt_q == SETTLE_LAST) state_d = S_POLL;
      end
      S_RD_RESP0: begin
        addr_c = ADDR_RESP0;
        if (!phase_q) begin
          phase_d = 1'b1;
        end else begin
          resp_d[15:0] = bus.reg_rd_data[15:0];
          state_d      = S_RD_RESP1;
        end
      end
      S_RD_RESP1: begin
        addr_c = ADDR_RESP1;
        if (!phase_q) begin
          phase_d = 1'b1;
        end else begin
          resp_d[31:16] = bus.reg_rd_data[15:0];
          state_d       = S_DONE;
        end
      end
      S_DONE: begin
        done_c  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Counter restarts on every state change (fresh budget per poll phase).
    cnt_d = (state_d != state_q) ? 16'h0 : cnt_inc;
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q   <= S_IDLE;
      phase_q   <= 1'b0;
      cnt_q     <= 16'h0;
      idx_q     <= 6'h0;
      flags_q   <= 8'h0;
      arg_q     <= 32'h0;
      resp_q    <= 32'h0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      phase_q   <= phase_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      flags_q   <= flags_d;
      arg_q     <= arg_d;
      resp_q    <= resp_d;
      timeout_q <= timeout_d;
    end
  end

  // Strobes are masked during RESET so an aborted sequence never emits a
  // write or a completion in the reset cycle itself.
  assign bus.req_ready   = ready_c;
  assign bus.reg_address = addr_c;
  assign bus.reg_wr_data = wdata_c;
  assign bus.reg_wr_en   = wr_en_c & ~RESET;
  assign bus.done        = done_c & ~RESET;
  assign bus.timeout     = timeout_q;
  assign bus.resp        = resp_q;

endmodule

// File: doc/sd_cmd_issuer.md
Name: sd_cmd_issuer

Overview:
Register-bus master that sits directly upstream of the SD host top level. It drives that block's reg_address / reg_wr_data / reg_wr_en port and consumes reg_rd_data. It accepts one SD command request (index, argument, command flags) per valid/ready handshake and runs the full register sequence for it:
- check that the CMD line is free,
- write argument low half, argument high half, then the command register,
- poll for completion with a timeout,
- read back the 32-bit response.
This removes per-command register choreography from the CPU/test side.

Parameters:
ADDR_ARG0, 12'h008, argument bits [15:0] register address
ADDR_ARG1, 12'h00A, argument bits [31:16] register address
ADDR_CMD, 12'h00E, command register address (write starts the command)
ADDR_PSR, 12'h024, present state register address; bit 0 = command inhibit (busy)
ADDR_RESP0, 12'h010, response bits [15:0] address
ADDR_RESP1, 12'h012, response bits [31:16] address
SETTLE_CYCLES, 4, idle cycles after the command write before the first busy poll
TIMEOUT_CYCLES, 4096, maximum cycles spent polling busy in one poll phase

Ports:
CLK  in  1  system clock, all logic on rising edge
RESET  in  1  synchronous, active-high reset
req_valid  in  1  command request valid
req_ready  out  1  issuer idle and able to accept
req_cmd_index  in  6  SD command index
req_cmd_flags  in  8  command register bits [7:0] (resp type, CRC/index check, data present, type)
req_arg  in  32  command argument
reg_address  out  12  register address to SD host
reg_wr_data  out  32  register write data; bits [31:16] always 0
reg_wr_en  out  1  one-cycle register write strobe
reg_rd_data  in  32  register read data; only bits [15:0] are used
done  out  1  one-cycle pulse: sequence finished
timeout  out  1  valid with done; 1 = busy never cleared
resp  out  32  {RESP1, RESP0}; valid from done until the next accept

Behaviour:
- One clock domain (CLK). Reset is synchronous and active-high (RESET).
- Reset values: req_ready=1, reg_address=0, reg_wr_data=0, reg_wr_en=0, done=0, timeout=0, resp=0, state IDLE.
- RESET asserted mid-sequence: the next edge returns to IDLE with reset values. No further writes are issued and no done is pulsed.
- Accept: req_valid && req_ready at an edge latches index, flags and arg, clears resp and timeout, and sets req_ready=0.
- Read access (2 cycles):
  - phase A drives the address;
  - phase B holds the same address, and the edge ending phase B registers reg_rd_data.
  - reg_wr_en=0 throughout.
- Write access (1 cycle): address and data driven with reg_wr_en=1 for exactly one cycle.
- States:
  - IDLE: reg_address=0, reg_wr_en=0.
  - PRECHECK: read ADDR_PSR.
    - bit0=0 → WR_ARG0.
    - bit0=1 → re-read.
    - Timeout counter cleared on entry and incremented every cycle in this state. If a sample shows bit0=1 with counter ≥ TIMEOUT_CYCLES → DONE with timeout=1, and no writes are issued.
  - WR_ARG0: write ADDR_ARG0 with arg[15:0].
  - WR_ARG1: write ADDR_ARG1 with arg[31:16].
  - WR_CMD: write ADDR_CMD with {2'b00, cmd_index, flags}.
  - SETTLE: SETTLE_CYCLES cycles, bus idle (address 0, no strobe).
  - POLL: same rules as PRECHECK, with a fresh counter.
    - bit0=0 → RD_RESP0.
    - Timeout → DONE with timeout=1 and resp=0; no response reads.
  - RD_RESP0: read into resp[15:0].
  - RD_RESP1: read into resp[31:16].
  - DONE: done=1 for one cycle, then IDLE with req_ready=1.
- req_valid while busy is ignored. A request is never lost because req_ready=0 in that period.
- No-wait latency: accept edge ends cycle 0; PRECHECK occupies cycles 1–2; writes occur in cycles 3, 4, 5; SETTLE 6–9; POLL 10–11; RESP0 12–13; RESP1 14–15; done=1 in cycle 16; req_ready=1 in cycle 17. Back-to-back requests are accepted in cycle 17.
- Each extra busy poll adds 2 cycles.
- Counter is 16 bits wide and saturates; it never wraps.

Test Plan:
- Reset, then request idx=8, flags=8'h1A, arg=32'h0000_01AA, PSR always 0. Required response:
  - writes 008←01AA at cycle 3, 00A←0000 at cycle 4, 00E←081A at cycle 5;
  - done at cycle 16, timeout=0;
  - model RESP0=0x01AA, RESP1=0x0000 → resp=32'h0000_01AA.
- PSR[0]=1 for 3 post-issue samples, then 0 → done at cycle 22; resp read correctly.
- TIMEOUT_CYCLES=16, PSR[0] stuck 1 after the command write → done with timeout=1, resp=0, and no reads of 010/012.
- PSR[0]=1 before issue and stuck, TIMEOUT_CYCLES=16 → done with timeout=1; zero reg_wr_en pulses observed.
- RESET pulsed in cycle 4 (after the ARG0 write) → no ARG1/CMD writes follow; req_ready=1 one cycle after RESET deasserts; a new request then completes normally.
- req_valid held high with two different requests queued by the bench → second request accepted exactly in cycle 17 of the first; the first's resp is stable until then.
